// File: rtl/hex_entry_display_if.sv
// hex_entry_display_if
//   Bundles the board-facing signals of hex_entry_display.
//   key_n : raw active-low pushbutton (asynchronous to the clock)
//   mode  : operation applied on a press (00 SHIFT, 01 INCR, 10 DECR, 11 CLEAR)
//   data  : nibble shifted in by SHIFT
//   hex   : active-low seven-segment outputs, digit k on hex[7k+6:7k]
//   ledr  : {overflow, 5'b0, fill count}
//   master drives the inputs (board/bench); slave is the controller.
interface hex_entry_display_if #(
  parameter int NUM_DIGITS = 6
);
  logic                    key_n;
  logic [1:0]              mode;
  logic [3:0]              data;
  logic [7*NUM_DIGITS-1:0] hex;
  logic [9:0]              ledr;

  modport master (
    output key_n,
    output mode,
    output data,
    input  hex,
    input  ledr
  );

  modport slave (
    input  key_n,
    input  mode,
    input  data,
    output hex,
    output ledr
  );
endinterface

// File: rtl/hex_entry_display.sv
// hex_entry_display
//   Multi-digit hexadecimal entry/display controller. A debounced pushbutton
//   commits one operation (shift a nibble in, increment, decrement, clear)
//   into a NUM_DIGITS-digit value register, which is shown on active-low
//   seven-segment displays with optional leading-zero blanking.
//   Ports:
//     Clock  : system clock, rising edge
//     Resetn : asynchronous active-low reset
//     bus    : hex_entry_display_if.slave (key_n, mode, data in; hex, ledr out)
module hex_entry_display #(
  parameter int NUM_DIGITS      = 6,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BLANK_LEADING   = 1
) (
  input  logic               Clock,
  input  logic               Resetn,
  hex_entry_display_if.slave bus
);

  localparam int VW    = 4 * NUM_DIGITS;
  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Fill count saturates at the number of digits.
  function automatic logic [3:0] sat_inc(input logic [3:0] f);
    if (f >= 4'(NUM_DIGITS)) return 4'(NUM_DIGITS);
    else                     return f + 4'd1;
  endfunction

  // Active-low segment decode, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  logic             sync_p0;
  logic             sync_p1;
  logic             db;
  logic [CNT_W-1:0] cnt;
  logic             press;
  logic [VW-1:0]    value;
  logic [VW-1:0]    value_shl;
  logic [3:0]       fill;
  logic             ovf;

  // Stage p0/p1: two-flop synchroniser for the asynchronous pushbutton.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= bus.key_n;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: db follows the synchronised level only after DEBOUNCE_CYCLES
  // consecutive mismatching samples; any agreeing sample restarts the count.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      db  <= 1'b1;
      cnt <= '0;
    end else if (sync_p1 == db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      db  <= sync_p1;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A press is the edge on which db is about to fall; mode/data are taken
  // from this very edge so the operation lands together with db.
  assign press     = db & ~sync_p1 & (cnt == CNT_LAST);
  assign value_shl = (value << 4) | VW'(bus.data);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      value <= '0;
      fill  <= '0;
      ovf   <= 1'b0;
    end else if (press) begin
      case (bus.mode)
        2'b00: begin
          value <= value_shl;
          fill  <= sat_inc(fill);
          if (value[VW-1 -: 4] != 4'd0) ovf <= 1'b1;
        end
        2'b01: begin
          value <= value + VW'(1);
          if (&value) ovf <= 1'b1;
        end
        2'b10: begin
          value <= value - VW'(1);
          if (value == '0) ovf <= 1'b1;
        end
        default: begin
          value <= '0;
          fill  <= '0;
          ovf   <= 1'b0;
        end
      endcase
    end
  end

  // Display decode. Scanning from the top digit down, a digit is blanked
  // while every digit from it upward has been zero; digit 0 always shows.
  always_comb begin
    logic       any_nz;
    logic [3:0] nib;
    bus.hex = '1;
    any_nz  = 1'b0;
    nib     = 4'd0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib    = value[4*k +: 4];
      any_nz = any_nz | (nib != 4'd0);
      if (BLANK_LEADING != 0 && k != 0 && !any_nz)
        bus.hex[7*k +: 7] = 7'b1111111;
      else
        bus.hex[7*k +: 7] = seg7(nib);
    end
  end

  assign bus.ledr = {ovf, 5'b00000, fill};

endmodule

// File: tb/tb_hex_entry_display.sv
// tb_hex_entry_display
//   Table-driven and randomized bench for hex_entry_display (6 digits,
//   DEBOUNCE_CYCLES=4, leading-zero blanking on).
module tb_hex_entry_display;

  localparam int ND = 6;
  localparam int DB = 4;
  localparam longint MOD = 64'h1000000;

  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic clk;
  logic rst_n;

  hex_entry_display_if #(.NUM_DIGITS(ND)) bus ();

  hex_entry_display #(
    .NUM_DIGITS(ND),
    .DEBOUNCE_CYCLES(DB),
    .BLANK_LEADING(1)
  ) dut (
    .Clock (clk),
    .Resetn(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  data;
    int          low;
    logic [23:0] exp_value;
    logic [9:0]  exp_ledr;
  } vec_t;

  vec_t vecs[$];

  // Reference model state.
  longint     m_value;
  int         m_fill;
  logic       m_ovf;
  logic [41:0] cur_hex;
  logic [9:0]  cur_ledr;

  function automatic logic [41:0] exp_hex(input longint v);
    logic [41:0] h;
    longint      upper;
    h = '1;
    for (int k = 0; k < ND; k++) begin
      upper = v >> (4 * k);
      if (k > 0 && upper == 0) h[7*k +: 7] = 7'b1111111;
      else                     h[7*k +: 7] = SEG[int'(upper % 16)];
    end
    return h;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_apply(input logic [1:0] mode, input logic [3:0] data);
    case (mode)
      2'b00: begin
        if ((m_value >> 20) != 0) m_ovf = 1'b1;
        m_value = (m_value * 16 + longint'(data)) % MOD;
        m_fill  = (m_fill + 1 > ND) ? ND : m_fill + 1;
      end
      2'b01: begin
        if (m_value == MOD - 1) m_ovf = 1'b1;
        m_value = (m_value + 1) % MOD;
      end
      2'b10: begin
        if (m_value == 0) m_ovf = 1'b1;
        m_value = (m_value + MOD - 1) % MOD;
      end
      default: begin
        m_value = 0;
        m_fill  = 0;
        m_ovf   = 1'b0;
      end
    endcase
  endtask

  // Holds key_n low for 'low' clock edges with mode/data steady, then
  // releases; mode/data are scrambled once the press edge is long past.
  task automatic do_op(input string name, input logic [1:0] mode, input logic [3:0] data,
                       input int low, input longint exp_value, input logic [9:0] exp_ledr);
    logic [41:0] nh;
    nh = exp_hex(exp_value);
    @(negedge clk);
    bus.mode  = mode;
    bus.data  = data;
    bus.key_n = 1'b0;
    for (int i = 1; i <= low + 10; i++) begin
      @(negedge clk);
      if (low >= DB && i == DB + 1) begin
        chk({name, " pre-edge hex"}, 64'(bus.hex), 64'(cur_hex));
        chk({name, " pre-edge ledr"}, 64'(bus.ledr), 64'(cur_ledr));
      end
      if (low >= DB + 2 && i == DB + 2) begin
        chk({name, " edge hex"}, 64'(bus.hex), 64'(nh));
        chk({name, " edge ledr"}, 64'(bus.ledr), 64'(exp_ledr));
      end
      if (i == low) bus.key_n = 1'b1;
      if (i >= 7) begin
        bus.mode = 2'($urandom_range(0, 3));
        bus.data = 4'($urandom_range(0, 15));
      end
    end
    chk({name, " hex"}, 64'(bus.hex), 64'(nh));
    chk({name, " ledr"}, 64'(bus.ledr), 64'(exp_ledr));
    cur_hex  = nh;
    cur_ledr = exp_ledr;
  endtask

  initial begin
    logic [1:0] md;
    logic [3:0] dt;
    int         lw;
    logic [9:0] el;

    rst_n    = 1'b0;
    bus.key_n = 1'b1;
    bus.mode = 2'b00;
    bus.data = 4'h0;

    // Stimulus table: {mode, data, low cycles, expected value, expected ledr}
    vecs.push_back('{2'b00, 4'h1, 6,  24'h000001, 10'h001});
    vecs.push_back('{2'b00, 4'h2, 6,  24'h000012, 10'h002});
    vecs.push_back('{2'b00, 4'h3, 6,  24'h000123, 10'h003});
    vecs.push_back('{2'b00, 4'h9, 3,  24'h000123, 10'h003});
    vecs.push_back('{2'b00, 4'h4, 10, 24'h001234, 10'h004});
    vecs.push_back('{2'b10, 4'h0, 6,  24'h001233, 10'h004});
    vecs.push_back('{2'b01, 4'h0, 6,  24'h001234, 10'h004});
    vecs.push_back('{2'b11, 4'h0, 6,  24'h000000, 10'h000});
    vecs.push_back('{2'b00, 4'hF, 6,  24'h00000F, 10'h001});
    vecs.push_back('{2'b00, 4'hF, 6,  24'h0000FF, 10'h002});
    vecs.push_back('{2'b00, 4'hF, 6,  24'h000FFF, 10'h003});
    vecs.push_back('{2'b00, 4'hF, 6,  24'h00FFFF, 10'h004});
    vecs.push_back('{2'b00, 4'hF, 6,  24'h0FFFFF, 10'h005});
    vecs.push_back('{2'b00, 4'hF, 6,  24'hFFFFFF, 10'h006});
    vecs.push_back('{2'b01, 4'h0, 6,  24'h000000, 10'h206});
    vecs.push_back('{2'b11, 4'h0, 6,  24'h000000, 10'h000});
    vecs.push_back('{2'b10, 4'h0, 6,  24'hFFFFFF, 10'h200});
    vecs.push_back('{2'b11, 4'h0, 6,  24'h000000, 10'h000});
    vecs.push_back('{2'b00, 4'h1, 6,  24'h000001, 10'h001});
    vecs.push_back('{2'b00, 4'h1, 6,  24'h000011, 10'h002});
    vecs.push_back('{2'b00, 4'h1, 6,  24'h000111, 10'h003});
    vecs.push_back('{2'b00, 4'h1, 6,  24'h001111, 10'h004});
    vecs.push_back('{2'b00, 4'h1, 6,  24'h011111, 10'h005});
    vecs.push_back('{2'b00, 4'h1, 6,  24'h111111, 10'h006});
    vecs.push_back('{2'b00, 4'h2, 6,  24'h111112, 10'h206});

    // Reset state, during and after reset.
    repeat (3) @(negedge clk);
    chk("reset hex", 64'(bus.hex), 64'(exp_hex(0)));
    chk("reset hex literal", 64'(bus.hex), 64'({{5{7'b1111111}}, 7'b1000000}));
    chk("reset ledr", 64'(bus.ledr), 64'(10'h000));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post-reset hex", 64'(bus.hex), 64'(exp_hex(0)));
    chk("post-reset ledr", 64'(bus.ledr), 64'(10'h000));
    cur_hex  = exp_hex(0);
    cur_ledr = 10'h000;

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].data, vecs[i].low,
            longint'(vecs[i].exp_value), vecs[i].exp_ledr);

    // Reset asserted in the middle of a held press aborts it; after release
    // the still-held key needs the full latency again.
    @(negedge clk);
    bus.mode  = 2'b00;
    bus.data  = 4'h5;
    bus.key_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async reset hex", 64'(bus.hex), 64'(exp_hex(0)));
    chk("async reset ledr", 64'(bus.ledr), 64'(10'h000));
    repeat (4) @(negedge clk);
    chk("held reset hex", 64'(bus.hex), 64'(exp_hex(0)));
    chk("held reset ledr", 64'(bus.ledr), 64'(10'h000));
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        chk("rst-press early hex", 64'(bus.hex), 64'(exp_hex(0)));
        chk("rst-press early ledr", 64'(bus.ledr), 64'(10'h000));
      end
      if (i == 6) begin
        chk("rst-press hex", 64'(bus.hex), 64'(exp_hex(5)));
        chk("rst-press ledr", 64'(bus.ledr), 64'(10'h001));
      end
    end
    bus.key_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst-press single op", 64'(bus.hex), 64'(exp_hex(5)));
    cur_hex  = exp_hex(5);
    cur_ledr = 10'h001;

    // Randomized operations against the arithmetic reference model.
    m_value = 5;
    m_fill  = 1;
    m_ovf   = 1'b0;
    for (int n = 0; n < 60; n++) begin
      md = 2'($urandom_range(0, 3));
      if (md == 2'b11 && $urandom_range(0, 2) != 0) md = 2'b00;
      dt = 4'($urandom_range(0, 15));
      lw = $urandom_range(1, 12);
      if (lw >= DB) model_apply(md, dt);
      el = {m_ovf, 5'b00000, 4'(m_fill)};
      do_op($sformatf("rand%0d", n), md, dt, lw, m_value, el);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
